mtt_walker: RTL and testbench
=============================

Name: mtt_walker

Overview:
- Two-level Memory Tracking Table (MTT) walker. Resolves a physical-address access request into allow / deny / fault by fetching table entries over a single read-only memory port.
- Sits directly upstream of mtt_top and feeds it the permission result for every checked access.
- One walk in flight at a time; one outstanding memory read at a time.

Parameters:
- PA_W, 34, physical address width in bits; legal range 31..64.
- DATA_W, 64, memory read data width; fixed at 64.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- mtt_en_i  in  1  0 = bypass, every request is allowed.
- mttp_base_i  in  PA_W-12  PPN of the L1 table (4 KiB aligned).
- flush_i  in  1  invalidates cached state (used only with the optional feature).
- req_valid_i  in  1  check request valid.
- req_ready_o  out  1  walker can accept a request.
- req_paddr_i  in  PA_W  physical address to check.
- req_write_i  in  1  1 = write access, 0 = read access.
- mem_req_valid_o  out  1  memory read request valid.
- mem_req_ready_i  in  1  memory accepts the read.
- mem_req_addr_o  out  PA_W  8-byte aligned read address.
- mem_rsp_valid_i  in  1  read data valid.
- mem_rsp_data_i  in  64  read data.
- mem_rsp_err_i  in  1  bus error on this read.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer takes the result.
- rsp_allow_o  out  1  access permitted.
- rsp_cause_o  out  2  0 = none, 1 = bus error, 2 = reserved encoding.

Behaviour:
- Reset values: all outputs 0 except req_ready_o = 1; FSM in IDLE.
- States: IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP.
- IDLE:
  - req_ready_o = 1 in IDLE only.
  - On a request handshake, latch paddr and write.
  - mtt_en_i = 0 → go to RESP with allow = 1, cause = 0; no memory access.
  - Otherwise → L1_REQ.
- L1_REQ: mem_req_valid_o = 1, mem_req_addr_o = {mttp_base_i, 12'b0} + (paddr[PA_W-1:30] << 3), truncated mod 2^PA_W. Address stays stable until mem_req_ready_i; handshake → L1_WAIT.
- L1_WAIT: on mem_rsp_valid_i, decode L1 entry bits [1:0]:
  - 00 → deny.
  - 01 → allow (whole 1 GiB region).
  - 10 → latch L2 base = entry[PA_W-1:12], go to L2_REQ.
  - 11 → cause 2.
- L2_REQ: address = {L2 base, 12'b0} + (paddr[29:17] << 3), mod 2^PA_W; same handshake rules as L1_REQ.
- L2_WAIT: on mem_rsp_valid_i, select field = entry[2*paddr[16:12]+1 : 2*paddr[16:12]]:
  - 00 → deny.
  - 01 → read-only: allow = !write.
  - 11 → allow.
  - 10 → cause 2.
- mem_rsp_err_i in either WAIT state → allow = 0, cause = 1; the entry is ignored.
- RESP: rsp_valid_o = 1; rsp_allow_o and rsp_cause_o held stable until rsp_ready_i; handshake → IDLE.
- Any nonzero cause forces allow = 0.
- mem_rsp_valid_i outside the WAIT states is ignored. This covers late responses after reset.
- Latency, zero-wait memory (request accepted cycle 0):
  - Bypass: rsp_valid_o at cycle 1.
  - L1-terminal walk: rsp_valid_o at cycle 3.
  - Full walk: rsp_valid_o at cycle 5.
- rst_i mid-walk → IDLE next cycle. The in-flight request is dropped and no response is produced.
- mtt_en_i and mttp_base_i are sampled when used. Software must not change them during a walk.

Optional Feature:
- MTT_L1_CACHE_EN defined: single-entry cache of {valid, L1 index, L1 entry} for entries of type 10.
  - A request whose paddr[PA_W-1:30] matches the valid entry skips L1_REQ/L1_WAIT and goes directly to L2_REQ. Full-walk latency becomes 3.
  - Filled on each type-10 L1 fetch without error.
  - Cleared by rst_i or flush_i; flush_i wins over a same-cycle fill.
- Undefined: no cache; flush_i is ignored; latency exactly as in Behaviour.

Decomposition:
- mtt_pkg holds:
  - FSM state enum.
  - L1 type encodings (MTT_L1_DENY / ALLOW / PTR / RSVD).
  - L2 permission encodings.
  - Cause codes.
  - Index bit-position constants (L1_LSB = 30, L2_LSB = 17, FLD_LSB = 12).
- One combinational sub-module, mtt_perm_decode: takes the 64-bit entry, level, field index and write; returns allow, cause and next-pointer.

Test Plan:
- PA_W = 34, mttp_base_i = 0x10000, paddr 0x0_4000_5000 read.
  - Memory stimulus: L1 at 0x1000_0008 returns 0x2000_0002; L2 at 0x2000_0000 returns 0xC00.
  - Required response: allow = 1, cause = 0, rsp_valid_o at cycle 5.
- Same addresses, write access, L2 returns 0x400 (field 01) → allow = 0, cause = 0.
- L1 entry 0x3 → allow = 0, cause = 2, exactly one memory read issued.
- mem_rsp_err_i = 1 on the L2 read → allow = 0, cause = 1; rsp_ready_i held low 4 cycles → outputs stable throughout.
- mtt_en_i = 0, any paddr → allow = 1 at cycle 1, mem_req_valid_o never asserted. rst_i asserted in L1_WAIT → IDLE; a late mem_rsp_valid_i is ignored and no rsp_valid_o follows.
- With MTT_L1_CACHE_EN: repeat test 1 → second walk issues only the L2 read, latency 3. After flush_i, the next walk fetches L1 again.

Source files
------------

// File: rtl/mtt_pkg.sv
// +--------------------------------------------------------------------+
// | mtt_pkg : shared types and encodings for the MTT walker            |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package mtt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L1_REQ  = 3'd1,
        ST_L1_WAIT = 3'd2,
        ST_L2_REQ  = 3'd3,
        ST_L2_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } mtt_state_t;

    localparam logic [1:0] MTT_L1_DENY  = 2'b00;
    localparam logic [1:0] MTT_L1_ALLOW = 2'b01;
    localparam logic [1:0] MTT_L1_PTR   = 2'b10;
    localparam logic [1:0] MTT_L1_RSVD  = 2'b11;

    localparam logic [1:0] MTT_L2_NONE  = 2'b00;
    localparam logic [1:0] MTT_L2_RO    = 2'b01;
    localparam logic [1:0] MTT_L2_RSVD  = 2'b10;
    localparam logic [1:0] MTT_L2_RW    = 2'b11;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_BUS    = 2'd1;
    localparam logic [1:0] CAUSE_RSVD   = 2'd2;

    localparam int L1_LSB  = 30;
    localparam int L2_LSB  = 17;
    localparam int FLD_LSB = 12;

endpackage

`default_nettype wire

// File: rtl/mtt_perm_decode.sv
// +--------------------------------------------------------------------+
// | mtt_perm_decode : combinational decode of one L1 or L2 MTT entry   |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module mtt_perm_decode
    import mtt_pkg::*;
#(
    parameter int PA_W = 34
) (
    input  logic [63:0]      i_entry,
    input  logic             i_level,
    input  logic [4:0]       i_fld_idx,
    input  logic             i_write,
    output logic             o_allow,
    output logic [1:0]       o_cause,
    output logic             o_ptr_valid,
    output logic [PA_W-13:0] o_next_ptr
);

    logic [1:0] w_fld;

    assign w_fld      = i_entry[{i_fld_idx, 1'b0} +: 2];
    assign o_next_ptr = i_entry[PA_W-1:FLD_LSB];

    always_comb begin
        o_allow     = 1'b0;
        o_cause     = CAUSE_NONE;
        o_ptr_valid = 1'b0;
        if (!i_level) begin
            case (i_entry[1:0])
                MTT_L1_DENY:  o_allow     = 1'b0;
                MTT_L1_ALLOW: o_allow     = 1'b1;
                MTT_L1_PTR:   o_ptr_valid = 1'b1;
                default:      o_cause     = CAUSE_RSVD;
            endcase
        end else begin
            case (w_fld)
                MTT_L2_NONE: o_allow = 1'b0;
                MTT_L2_RO:   o_allow = !i_write;
                MTT_L2_RW:   o_allow = 1'b1;
                default:     o_cause = CAUSE_RSVD;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mtt_walker.sv
// +--------------------------------------------------------------------+
// | mtt_walker : two-level MTT walker, allow/deny/fault per access     |
// | Optional single-entry L1 pointer cache: define MTT_L1_CACHE_EN     |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module mtt_walker
    import mtt_pkg::*;
#(
    parameter int PA_W   = 34,
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mtt_en_i,
    input  logic [PA_W-13:0]  mttp_base_i,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [PA_W-1:0]   req_paddr_i,
    input  logic              req_write_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [PA_W-1:0]   mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    input  logic              mem_rsp_err_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_allow_o,
    output logic [1:0]        rsp_cause_o
);

    mtt_state_t                r_state;
    logic [L1_LSB-1:FLD_LSB]   r_paddr;
    logic                      r_write;

    logic                      w_dec_allow;
    logic [1:0]                w_dec_cause;
    logic                      w_dec_ptr;
    logic [PA_W-13:0]          w_dec_next;
    logic                      w_hit;
    logic [PA_W-13:0]          w_c_ptr;
    logic [PA_W-1:0]           w_l1_addr;
    logic [PA_W-1:0]           w_l2_off_lat;
    logic [PA_W-1:0]           w_l2_off_req;
    logic                      w_unused;

    // Table offsets are index * 8; sums wrap modulo 2^PA_W.
    assign w_l1_addr    = {mttp_base_i, 12'b0}
                        + ({{L1_LSB{1'b0}}, req_paddr_i[PA_W-1:L1_LSB]} << 3);
    assign w_l2_off_lat = {{(PA_W-13){1'b0}}, r_paddr[L1_LSB-1:L2_LSB]} << 3;
    assign w_l2_off_req = {{(PA_W-13){1'b0}}, req_paddr_i[L1_LSB-1:L2_LSB]} << 3;

    mtt_perm_decode #(
        .PA_W (PA_W)
    ) u_decode (
        .i_entry     (mem_rsp_data_i),
        .i_level     (r_state == ST_L2_WAIT),
        .i_fld_idx   (r_paddr[FLD_LSB+4:FLD_LSB]),
        .i_write     (r_write),
        .o_allow     (w_dec_allow),
        .o_cause     (w_dec_cause),
        .o_ptr_valid (w_dec_ptr),
        .o_next_ptr  (w_dec_next)
    );

`ifdef MTT_L1_CACHE_EN
    logic                r_c_valid;
    logic [PA_W-31:0]    r_c_idx;
    logic [PA_W-31:0]    r_c_pidx;
    logic [PA_W-13:0]    r_c_ptr;

    always_ff @(posedge clk_i) begin
        if (r_state == ST_IDLE && req_valid_i) begin
            r_c_pidx <= req_paddr_i[PA_W-1:L1_LSB];
        end
        // Flush takes priority over a fill landing in the same cycle.
        if (rst_i || flush_i) begin
            r_c_valid <= 1'b0;
        end else if (r_state == ST_L1_WAIT && mem_rsp_valid_i && !mem_rsp_err_i && w_dec_ptr) begin
            r_c_valid <= 1'b1;
            r_c_idx   <= r_c_pidx;
            r_c_ptr   <= w_dec_next;
        end
    end

    assign w_hit    = r_c_valid && !flush_i && (r_c_idx == req_paddr_i[PA_W-1:L1_LSB]);
    assign w_c_ptr  = r_c_ptr;
    assign w_unused = &{1'b0, req_paddr_i[FLD_LSB-1:0]};
`else
    assign w_hit    = 1'b0;
    assign w_c_ptr  = '0;
    assign w_unused = &{1'b0, flush_i, req_paddr_i[FLD_LSB-1:0]};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= ST_IDLE;
            r_paddr         <= '0;
            r_write         <= 1'b0;
            req_ready_o     <= 1'b1;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_allow_o     <= 1'b0;
            rsp_cause_o     <= CAUSE_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_paddr     <= req_paddr_i[L1_LSB-1:FLD_LSB];
                        r_write     <= req_write_i;
                        req_ready_o <= 1'b0;
                        if (!mtt_en_i) begin
                            rsp_valid_o <= 1'b1;
                            rsp_allow_o <= 1'b1;
                            rsp_cause_o <= CAUSE_NONE;
                            r_state     <= ST_RESP;
                        end else if (w_hit) begin
                            mem_req_valid_o <= 1'b1;
                            mem_req_addr_o  <= {w_c_ptr, 12'b0} + w_l2_off_req;
                            r_state         <= ST_L2_REQ;
                        end else begin
                            mem_req_valid_o <= 1'b1;
                            mem_req_addr_o  <= w_l1_addr;
                            r_state         <= ST_L1_REQ;
                        end
                    end
                end
                ST_L1_REQ, ST_L2_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        r_state         <= (r_state == ST_L1_REQ) ? ST_L1_WAIT : ST_L2_WAIT;
                    end
                end
                ST_L1_WAIT, ST_L2_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        if (mem_rsp_err_i) begin
                            rsp_valid_o <= 1'b1;
                            rsp_allow_o <= 1'b0;
                            rsp_cause_o <= CAUSE_BUS;
                            r_state     <= ST_RESP;
                        end else if (r_state == ST_L1_WAIT && w_dec_ptr) begin
                            mem_req_valid_o <= 1'b1;
                            mem_req_addr_o  <= {w_dec_next, 12'b0} + w_l2_off_lat;
                            r_state         <= ST_L2_REQ;
                        end else begin
                            rsp_valid_o <= 1'b1;
                            rsp_allow_o <= w_dec_allow && (w_dec_cause == CAUSE_NONE);
                            rsp_cause_o <= w_dec_cause;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_allow_o <= 1'b0;
                        rsp_cause_o <= CAUSE_NONE;
                        req_ready_o <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_valid_o <= 1'b0;
                    rsp_valid_o     <= 1'b0;
                    req_ready_o     <= 1'b1;
                    r_state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mtt_walker.sv
// +--------------------------------------------------------------------+
// | tb_mtt_walker : directed self-checking bench for mtt_walker        |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mtt_walker;

    localparam int PA_W = 34;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              mtt_en_i;
    logic [PA_W-13:0]  mttp_base_i;
    logic              flush_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [PA_W-1:0]   req_paddr_i;
    logic              req_write_i;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [PA_W-1:0]   mem_req_addr_o;
    logic              mem_rsp_valid_i = 1'b0;
    logic [63:0]       mem_rsp_data_i  = 64'h0;
    logic              mem_rsp_err_i   = 1'b0;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_allow_o;
    logic [1:0]        rsp_cause_o;

    int                n_cmp = 0;
    int                n_err = 0;

    // Memory model state: main process configures, responder process serves.
    logic [PA_W-1:0]   l1_addr;
    logic [63:0]       l1_data;
    logic              l1_err;
    logic [63:0]       l2_data;
    logic              l2_err;
    logic              mem_hold;
    int                n_reads = 0;
    logic [PA_W-1:0]   addr_log [64];
    logic              pend = 1'b0;
    logic [PA_W-1:0]   pend_addr;

    mtt_walker #(
        .PA_W   (PA_W),
        .DATA_W (64)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .mtt_en_i        (mtt_en_i),
        .mttp_base_i     (mttp_base_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_paddr_i     (req_paddr_i),
        .req_write_i     (req_write_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_allow_o     (rsp_allow_o),
        .rsp_cause_o     (rsp_cause_o)
    );

    always #5 clk_i = ~clk_i;

    // Zero-wait responder: answers in the cycle after an accepted read.
    always @(posedge clk_i) begin : p_mem
        logic            hs;
        logic [PA_W-1:0] a;
        hs = mem_req_valid_o && mem_req_ready_i;
        a  = mem_req_addr_o;
        if (hs) begin
            addr_log[n_reads % 64] = a;
            n_reads++;
        end
        #1;
        if (hs && mem_hold) begin
            pend      = 1'b1;
            pend_addr = a;
        end
        if ((hs && !mem_hold) || (pend && !mem_hold)) begin
            if (!hs) a = pend_addr;
            pend            = 1'b0;
            mem_rsp_valid_i = 1'b1;
            if (a == l1_addr) begin
                mem_rsp_data_i = l1_data;
                mem_rsp_err_i  = l1_err;
            end else begin
                mem_rsp_data_i = l2_data;
                mem_rsp_err_i  = l2_err;
            end
        end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = 64'h0;
            mem_rsp_err_i   = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_mem(input logic [63:0] d1, input logic e1, input logic [63:0] d2, input logic e2);
        l1_data = d1;
        l1_err  = e1;
        l2_data = d2;
        l2_err  = e2;
    endtask

    // Issue one request; returns cycles from acceptance to rsp_valid_o.
    task automatic walk(input logic [PA_W-1:0] pa, input logic wr, output int lat);
        req_valid_i = 1'b1;
        req_paddr_i = pa;
        req_write_i = wr;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 40) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [PA_W-1:0] pa, input logic wr,
                            input logic exp_allow, input logic [1:0] exp_cause,
                            input int exp_lat, input int exp_reads);
        int lat;
        int r0;
        pulse_flush();
        r0 = n_reads;
        walk(pa, wr, lat);
        check_eq({tag, "_lat"},   lat, exp_lat);
        check_eq({tag, "_allow"}, rsp_allow_o, exp_allow);
        check_eq({tag, "_cause"}, rsp_cause_o, exp_cause);
        check_eq({tag, "_reads"}, n_reads - r0, exp_reads);
        take_rsp();
        check_eq({tag, "_idle"},  {req_ready_o, rsp_valid_o}, 2'b10);
    endtask

    initial begin : p_main
        int lat;
        int r0;
        int seen;

        rst_i           = 1'b1;
        mtt_en_i        = 1'b1;
        mttp_base_i     = 22'h10000;
        flush_i         = 1'b0;
        req_valid_i     = 1'b0;
        req_paddr_i     = '0;
        req_write_i     = 1'b0;
        mem_req_ready_i = 1'b1;
        rsp_ready_i     = 1'b0;
        mem_hold        = 1'b0;
        l1_addr         = 34'h0_1000_0008;
        set_mem(64'h2000_0002, 1'b0, 64'hC00, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        check_eq("reset_ready",  req_ready_o, 1'b1);
        check_eq("reset_outs",   {mem_req_valid_o, rsp_valid_o, rsp_allow_o, rsp_cause_o}, 5'b0);
        check_eq("reset_addr",   mem_req_addr_o, 34'h0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Full walk, read, field 5 = 11.
        r0 = n_reads;
        run_case("full_rd", 34'h0_4000_5000, 1'b0, 1'b1, 2'd0, 5, 2);
        check_eq("full_rd_l1addr", addr_log[r0 % 64],       34'h0_1000_0008);
        check_eq("full_rd_l2addr", addr_log[(r0 + 1) % 64], 34'h0_2000_0000);

        // Read-only field: write denied, read allowed.
        set_mem(64'h2000_0002, 1'b0, 64'h400, 1'b0);
        run_case("ro_wr", 34'h0_4000_5000, 1'b1, 1'b0, 2'd0, 5, 2);
        run_case("ro_rd", 34'h0_4000_5000, 1'b0, 1'b1, 2'd0, 5, 2);

        // Reserved L2 field.
        set_mem(64'h2000_0002, 1'b0, 64'h800, 1'b0);
        run_case("l2_rsvd", 34'h0_4000_5000, 1'b0, 1'b0, 2'd2, 5, 2);

        // L1 terminal types.
        set_mem(64'h3, 1'b0, 64'hC00, 1'b0);
        run_case("l1_rsvd", 34'h0_4000_5000, 1'b0, 1'b0, 2'd2, 3, 1);
        set_mem(64'h1, 1'b0, 64'h0, 1'b0);
        run_case("l1_allow", 34'h0_4000_5000, 1'b1, 1'b1, 2'd0, 3, 1);
        l1_addr = 34'h0_1000_0078;
        set_mem(64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        r0 = n_reads;
        run_case("l1_deny", 34'h3_C000_0000, 1'b0, 1'b0, 2'd0, 3, 1);
        check_eq("l1_deny_addr", addr_log[r0 % 64], 34'h0_1000_0078);

        // Highest L2 index and field 31 (01), every other field 11.
        l1_addr = 34'h0_1000_0008;
        set_mem(64'h2000_0002, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        r0 = n_reads;
        run_case("f31_wr", 34'h0_7FFF_F000, 1'b1, 1'b0, 2'd0, 5, 2);
        check_eq("f31_l2addr", addr_log[(r0 + 1) % 64], 34'h0_2000_FFF8);
        run_case("f31_rd", 34'h0_7FFF_F000, 1'b0, 1'b1, 2'd0, 5, 2);

        // Bus error on L1 read.
        set_mem(64'h2000_0002, 1'b1, 64'hC00, 1'b0);
        run_case("l1_err", 34'h0_4000_5000, 1'b0, 1'b0, 2'd1, 3, 1);

        // Bus error on L2 read, response held while consumer stalls.
        set_mem(64'h2000_0002, 1'b0, 64'hC00, 1'b1);
        pulse_flush();
        walk(34'h0_4000_5000, 1'b0, lat);
        check_eq("l2_err_lat", lat, 5);
        for (int i = 0; i < 4; i++) begin
            check_eq("l2_err_hold", {rsp_valid_o, rsp_allow_o, rsp_cause_o}, 4'b1001);
            @(posedge clk_i);
            #1;
        end
        check_eq("l2_err_final", {rsp_valid_o, rsp_allow_o, rsp_cause_o}, 4'b1001);
        take_rsp();

        // Bypass.
        mtt_en_i = 1'b0;
        set_mem(64'h0, 1'b0, 64'h0, 1'b0);
        run_case("bypass", 34'h3_FFFF_FFFF, 1'b1, 1'b1, 2'd0, 1, 0);
        mtt_en_i = 1'b1;

        // Reset while waiting for the L1 response; late response must be ignored.
        set_mem(64'h2000_0002, 1'b0, 64'hC00, 1'b0);
        mem_hold = 1'b1;
        r0 = n_reads;
        req_valid_i = 1'b1;
        req_paddr_i = 34'h0_4000_5000;
        req_write_i = 1'b0;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_eq("rst_mid_reads", n_reads - r0, 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_eq("rst_mid_idle", {req_ready_o, mem_req_valid_o, rsp_valid_o}, 3'b100);
        mem_hold = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            #1;
            if (rsp_valid_o || mem_req_valid_o || !req_ready_o) seen++;
        end
        check_eq("rst_late_ignored", seen, 0);
        run_case("after_rst", 34'h0_4000_5000, 1'b0, 1'b1, 2'd0, 5, 2);

`ifdef MTT_L1_CACHE_EN
        // Fill, hit (L2 read only), then flush forces an L1 fetch again.
        run_case("c_fill", 34'h0_4000_5000, 1'b0, 1'b1, 2'd0, 5, 2);
        r0 = n_reads;
        walk(34'h0_4000_5000, 1'b0, lat);
        check_eq("c_hit_lat",   lat, 3);
        check_eq("c_hit_reads", n_reads - r0, 1);
        check_eq("c_hit_addr",  addr_log[r0 % 64], 34'h0_2000_0000);
        check_eq("c_hit_allow", rsp_allow_o, 1'b1);
        take_rsp();
        run_case("c_flushed", 34'h0_4000_5000, 1'b0, 1'b1, 2'd0, 5, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
